softermax_drain: RTL and testbench

Row drain engine that sits behind `softermax` and empties its probability buffer. After `softermax` signals a finished row on `final_out_valid`, the block sweeps `read_addr` over all `ROW_WIDTH` entries and collects `prob_buffer_out` values despite the buffer's one-cycle read latency. It then presents the values in address order on a valid/ready stream, with an index and a last-element marker, to the downstream matmul/writeback path. With `out_ready` held high it sustains one element per cycle.

---
 rtl/softermax_drain.sv | 118 +++++++++++
 tb/tb_softermax_drain.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/softermax_drain.sv
// Row drain engine behind softermax: sweeps the probability buffer, hides its
// one-cycle read latency with a 2-entry FIFO and streams the row out with index/last.
module softermax_drain #(
   parameter int LARGE_SIZE = 32,
   parameter int ROW_WIDTH  = 8,
   localparam int AW        = $clog2(ROW_WIDTH)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                final_out_valid,
   output logic [AW-1:0]       read_addr,
   input  logic [LARGE_SIZE:0] prob_buffer_out,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [LARGE_SIZE:0] out_data,
   output logic [AW-1:0]       out_index,
   output logic                out_last,
   output logic                busy,
   output logic                row_done,
   output logic                overrun
);

   localparam logic [AW-1:0] LAST_IDX = AW'(ROW_WIDTH - 1);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

   state_t              state;
   logic [LARGE_SIZE:0] fifo_data [2];
   logic [AW-1:0]       fifo_idx  [2];
   logic                rd_ptr;
   logic                wr_ptr;
   logic [1:0]          fifo_count;
   logic                inflight;
   logic [AW-1:0]       inflight_idx;
   logic                pop;
   logic                issue;
   logic                last_hs;
   logic [2:0]          credit;

   always_comb begin
      out_valid = (fifo_count != '0);
      out_data  = fifo_data[rd_ptr];
      out_index = fifo_idx[rd_ptr];
      out_last  = out_valid && (out_index == LAST_IDX);
      pop       = out_valid && out_ready;
      last_hs   = pop && out_last;
      // FIFO entries plus the read in flight must stay below 2 after this cycle's pop
      credit    = {1'b0, fifo_count} + {2'b0, inflight};
      issue     = (state == FETCH) && (credit < (3'd2 + {2'b0, pop}));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         read_addr    <= '0;
         busy         <= 1'b0;
         row_done     <= 1'b0;
         overrun      <= 1'b0;
         inflight     <= 1'b0;
         inflight_idx <= '0;
         rd_ptr       <= 1'b0;
         wr_ptr       <= 1'b0;
         fifo_count   <= '0;
         fifo_data[0] <= '0;
         fifo_data[1] <= '0;
         fifo_idx[0]  <= '0;
         fifo_idx[1]  <= '0;
      end else begin
         row_done <= last_hs;
         if (final_out_valid && busy && !last_hs)
            overrun <= 1'b1;

         inflight <= issue;
         if (issue) begin
            inflight_idx <= read_addr;
            read_addr    <= read_addr + AW'(1);
         end

         if (inflight) begin
            fifo_data[wr_ptr] <= prob_buffer_out;
            fifo_idx[wr_ptr]  <= inflight_idx;
            wr_ptr            <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};

         case (state)
            IDLE: begin
               if (final_out_valid) begin
                  state <= FETCH;
                  busy  <= 1'b1;
               end
            end
            FETCH: begin
               if (issue && (read_addr == LAST_IDX))
                  state <= DRAIN;
            end
            DRAIN: begin
               // A start coinciding with the last handshake chains straight into the next row
               if (last_hs) begin
                  if (final_out_valid) begin
                     state <= FETCH;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_softermax_drain.sv
// Directed self-checking bench for softermax_drain with a one-cycle-latency buffer model.
module tb_softermax_drain;

   localparam int RW = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        final_out_valid;
   logic [2:0]  read_addr;
   logic [32:0] prob_buffer_out;
   logic        out_valid;
   logic        out_ready;
   logic [32:0] out_data;
   logic [2:0]  out_index;
   logic        out_last;
   logic        busy;
   logic        row_done;
   logic        overrun;

   logic [32:0] rowbuf [RW];
   int checks = 0;
   int errors = 0;

   softermax_drain #(.LARGE_SIZE(32), .ROW_WIDTH(RW)) dut (
      .clk(clk), .rst_n(rst_n), .final_out_valid(final_out_valid),
      .read_addr(read_addr), .prob_buffer_out(prob_buffer_out),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_index(out_index), .out_last(out_last), .busy(busy),
      .row_done(row_done), .overrun(overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) prob_buffer_out <= rowbuf[read_addr];

   // Pulse start for one cycle; returns at the negedge after the start edge E.
   task automatic start_row();
      @(negedge clk) final_out_valid = 1'b1;
      @(negedge clk) final_out_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; final_out_valid = 1'b0; out_ready = 1'b0;
      for (int i = 0; i < RW; i++) rowbuf[i] = 33'(i) * 33'h100;
      @(negedge clk);
      checks++;
      if ({read_addr, out_valid, out_data, out_index, out_last, busy, row_done, overrun} !== '0) begin
         errors++;
         $display("FAIL reset_state: got addr=%0d v=%b d=%h idx=%0d last=%b busy=%b done=%b ovr=%b, expected all zero",
                  read_addr, out_valid, out_data, out_index, out_last, busy, row_done, overrun);
      end
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_basic();
      for (int i = 0; i < RW; i++) rowbuf[i] = 33'(i) * 33'h100;
      out_ready = 1'b1;
      start_row();
      checks++;
      if (busy !== 1'b1 || read_addr !== 3'd0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_start: got busy=%b addr=%0d v=%b, expected 1 0 0", busy, read_addr, out_valid);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_latency: out_valid=%b at E+1, expected 0", out_valid);
      end
      @(negedge clk);
      for (int i = 0; i < RW; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_data !== 33'(i) * 33'h100 || out_index !== 3'(i) ||
             out_last !== (i == RW - 1) || row_done !== 1'b0) begin
            errors++;
            $display("FAIL basic_elem%0d: got v=%b d=%h idx=%0d last=%b done=%b, expected 1 %h %0d %b 0",
                     i, out_valid, out_data, out_index, out_last, row_done, 33'(i) * 33'h100, i, i == RW - 1);
         end
         @(negedge clk);
      end
      checks++;
      if (row_done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || overrun !== 1'b0) begin
         errors++;
         $display("FAIL basic_done: got done=%b busy=%b v=%b ovr=%b, expected 1 0 0 0", row_done, busy, out_valid, overrun);
      end
      @(negedge clk);
      checks++;
      if (row_done !== 1'b0) begin
         errors++;
         $display("FAIL basic_pulse: row_done=%b, expected 0", row_done);
      end
   endtask

   task automatic test_backpressure();
      int          nxt = 0;
      int          cyc = 0;
      logic        stalled = 1'b0;
      logic [32:0] held_d = '0;
      logic [2:0]  held_i = '0;
      for (int i = 0; i < RW; i++) rowbuf[i] = 33'h1_2345_0000 + 33'(i) * 33'h11;
      out_ready = 1'b0;
      start_row();
      while (nxt < RW && cyc < 200) begin
         if (stalled) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== held_d || out_index !== held_i) begin
               errors++;
               $display("FAIL bp_stable: got v=%b d=%h idx=%0d, expected 1 %h %0d", out_valid, out_data, out_index, held_d, held_i);
            end
         end
         if (read_addr != 3'd0 && int'(read_addr) > nxt + 2) begin
            checks++; errors++;
            $display("FAIL bp_ahead: read_addr=%0d, expected at most %0d", read_addr, nxt + 2);
         end
         out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
         if (out_valid && out_ready) begin
            checks++;
            if (out_data !== rowbuf[nxt] || out_index !== 3'(nxt) || out_last !== (nxt == RW - 1)) begin
               errors++;
               $display("FAIL bp_elem%0d: got d=%h idx=%0d last=%b, expected %h %0d %b",
                        nxt, out_data, out_index, out_last, rowbuf[nxt], nxt, nxt == RW - 1);
            end
            nxt++;
         end
         stalled = out_valid && !out_ready;
         held_d  = out_data;
         held_i  = out_index;
         cyc++;
         @(negedge clk);
      end
      checks++;
      if (nxt != RW || row_done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL bp_complete: got %0d elems done=%b busy=%b, expected %0d 1 0", nxt, row_done, busy, RW);
      end
      out_ready = 1'b1;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < RW; i++) rowbuf[i] = 33'h0_0000_0040 + 33'(i);
      out_ready = 1'b1;
      start_row();
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < RW; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_index !== 3'(i) || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_row1_%0d: got v=%b idx=%0d busy=%b, expected 1 %0d 1", i, out_valid, out_index, busy, i);
         end
         if (i == RW - 1) final_out_valid = 1'b1;
         @(negedge clk);
      end
      final_out_valid = 1'b0;
      checks++;
      if (row_done !== 1'b1 || busy !== 1'b1 || read_addr !== 3'd0 || overrun !== 1'b0) begin
         errors++;
         $display("FAIL b2b_chain: got done=%b busy=%b addr=%0d ovr=%b, expected 1 1 0 0", row_done, busy, read_addr, overrun);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b1 || row_done !== 1'b0) begin
         errors++;
         $display("FAIL b2b_gap: got v=%b busy=%b done=%b, expected 0 1 0", out_valid, busy, row_done);
      end
      @(negedge clk);
      for (int i = 0; i < RW; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_index !== 3'(i) || out_data !== rowbuf[i] || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_row2_%0d: got v=%b idx=%0d d=%h busy=%b, expected 1 %0d %h 1",
                     i, out_valid, out_index, out_data, busy, i, rowbuf[i]);
         end
         @(negedge clk);
      end
      checks++;
      if (row_done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_end: got done=%b busy=%b, expected 1 0", row_done, busy);
      end
   endtask

   task automatic test_overrun();
      out_ready = 1'b1;
      start_row();
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < RW; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_index !== 3'(i) || out_data !== rowbuf[i]) begin
            errors++;
            $display("FAIL ovr_elem%0d: got v=%b idx=%0d d=%h, expected 1 %0d %h", i, out_valid, out_index, out_data, i, rowbuf[i]);
         end
         final_out_valid = (i == 3);
         @(negedge clk);
      end
      final_out_valid = 1'b0;
      checks++;
      if (row_done !== 1'b1 || busy !== 1'b0 || overrun !== 1'b1) begin
         errors++;
         $display("FAIL ovr_done: got done=%b busy=%b ovr=%b, expected 1 0 1", row_done, busy, overrun);
      end
      repeat (5) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || overrun !== 1'b1) begin
         errors++;
         $display("FAIL ovr_no_extra: got busy=%b v=%b ovr=%b, expected 0 0 1", busy, out_valid, overrun);
      end
   endtask

   task automatic test_reset_mid_row();
      out_ready = 1'b1;
      start_row();
      @(negedge clk);
      @(negedge clk);
      repeat (5) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({read_addr, out_valid, out_data, out_index, out_last, busy, row_done, overrun} !== '0) begin
         errors++;
         $display("FAIL midrst_state: got addr=%0d v=%b d=%h idx=%0d last=%b busy=%b done=%b ovr=%b, expected all zero",
                  read_addr, out_valid, out_data, out_index, out_last, busy, row_done, overrun);
      end
      @(negedge clk) rst_n = 1'b1;
      start_row();
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_index !== 3'd0 || out_data !== rowbuf[0]) begin
         errors++;
         $display("FAIL midrst_restart: got v=%b idx=%0d d=%h, expected 1 0 %h", out_valid, out_index, out_data, rowbuf[0]);
      end
      repeat (RW + 2) @(negedge clk);
   endtask

   task automatic test_signed_extremes();
      rowbuf[0] = 33'h1_0000_0000;
      rowbuf[1] = 33'h0_FFFF_FFFF;
      rowbuf[2] = 33'h0_0000_0000;
      rowbuf[3] = 33'h1_FFFF_FFFF;
      rowbuf[4] = 33'h0_8000_0000;
      rowbuf[5] = 33'h1_7FFF_FFFF;
      rowbuf[6] = 33'h0_0000_0001;
      rowbuf[7] = 33'h1_5555_AAAA;
      out_ready = 1'b1;
      start_row();
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < RW; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_data !== rowbuf[i]) begin
            errors++;
            $display("FAIL signed_elem%0d: got v=%b d=%h, expected 1 %h", i, out_valid, out_data, rowbuf[i]);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_back_to_back();
      test_overrun();
      test_reset_mid_row();
      test_signed_extremes();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
